// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding, PC step and reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DROP  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_jcache.sv
// Direct-mapped jump cache: combinational lookup, one write port, valid bits cleared on reset.
module ifetch_jcache
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] target,
    output logic        link,
    input  logic        update,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_link
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] link_q;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] rd_tag;
    logic [TW-1:0] wr_tag;
    logic          unused_bits;

    assign rd_idx      = lookup_pc[IW+1:2];
    assign rd_tag      = lookup_pc[31:IW+2];
    assign wr_idx      = update_pc[IW+1:2];
    assign wr_tag      = update_pc[31:IW+2];
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    // Reads come straight from the arrays, so a same-edge write is not yet visible.
    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target = target_q[rd_idx];
    assign link   = link_q[rd_idx];

    always_ff @(negedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (update) begin
            valid_q[wr_idx]  <= 1'b1;
            link_q[wr_idx]   <= update_link;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= word_align(update_target);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, memory request handshake, optional jump-cache prediction.
// The jump cache is built only when IFETCH_JCACHE_EN is defined.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int          JC_ENTRIES = 8,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable_regwalls,
    input  logic         do_hazard,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         jc_update,
    input  logic [31:0]  jc_update_pc,
    input  logic [31:0]  jc_update_target,
    input  logic         jc_update_link,
    output logic         im_req,
    output logic [31:0]  im_addr,
    input  logic         im_ready,
    input  logic [31:0]  im_rdata,
    output logic [31:0]  oIF_instruction,
    output logic [31:0]  oIF_current_pc,
    output logic         oIF_do_jcache,
    output logic         oIF_do_jcache_link,
    output logic         fetch_busy,
    output fetch_state_e state
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] drop_addr;
    logic        jc_hit;
    logic        jc_link;
    logic [31:0] jc_target;
    logic        consume;

`ifdef IFETCH_JCACHE_EN
    ifetch_jcache #(.ENTRIES(JC_ENTRIES)) u_jcache (
        .clock         (clock),
        .reset         (reset),
        .lookup_pc     (pc),
        .hit           (jc_hit),
        .target        (jc_target),
        .link          (jc_link),
        .update        (jc_update),
        .update_pc     (jc_update_pc),
        .update_target (jc_update_target),
        .update_link   (jc_update_link)
    );
`else
    localparam int unused_entries = JC_ENTRIES;
    logic unused_jc;
    assign unused_jc = ^{jc_update, jc_update_pc, jc_update_target, jc_update_link};
    assign jc_hit    = 1'b0;
    assign jc_link   = 1'b0;
    assign jc_target = '0;
`endif

    assign consume    = enable_regwalls && !do_hazard;
    assign im_req     = (state != S_VALID);
    assign fetch_busy = (state != S_VALID);
    // While draining a cancelled access the bus must keep the address it was issued with.
    assign im_addr    = (state == S_DROP) ? drop_addr : pc;

    always_ff @(negedge clock) begin
        if (reset) begin
            state              <= S_REQ;
            pc                 <= word_align(RESET_PC);
            next_pc            <= word_align(RESET_PC);
            drop_addr          <= word_align(RESET_PC);
            oIF_instruction    <= NOP_INSTR;
            oIF_current_pc     <= '0;
            oIF_do_jcache      <= 1'b0;
            oIF_do_jcache_link <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        pc        <= word_align(redirect_pc);
                        drop_addr <= pc;
                        state     <= im_ready ? S_REQ : S_DROP;
                    end else if (im_ready) begin
                        oIF_instruction    <= im_rdata;
                        oIF_current_pc     <= pc;
                        oIF_do_jcache      <= jc_hit;
                        oIF_do_jcache_link <= jc_hit && jc_link;
                        next_pc            <= jc_hit ? word_align(jc_target) : pc + PC_STEP;
                        state              <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (redirect || consume) begin
                        pc                 <= redirect ? word_align(redirect_pc) : next_pc;
                        state              <= S_REQ;
                        oIF_instruction    <= NOP_INSTR;
                        oIF_current_pc     <= '0;
                        oIF_do_jcache      <= 1'b0;
                        oIF_do_jcache_link <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        pc <= word_align(redirect_pc);
                    end else if (im_ready) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed plus randomized bench for ifetch_unit against a specification-level fetch model.
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam int JCE = 8;
`ifdef IFETCH_JCACHE_EN
    localparam bit JC_ON = 1'b1;
`else
    localparam bit JC_ON = 1'b0;
`endif

    logic         clock = 1'b1;
    logic         reset;
    logic         enable_regwalls;
    logic         do_hazard;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         jc_update;
    logic [31:0]  jc_update_pc;
    logic [31:0]  jc_update_target;
    logic         jc_update_link;
    logic         im_req;
    logic [31:0]  im_addr;
    logic         im_ready;
    logic [31:0]  im_rdata;
    logic [31:0]  oIF_instruction;
    logic [31:0]  oIF_current_pc;
    logic         oIF_do_jcache;
    logic         oIF_do_jcache_link;
    logic         fetch_busy;
    fetch_state_e state;

    int checks = 0;
    int errors = 0;

    // Reference state: PC of the next fetch, predicted successor, and the jump table.
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    bit          m_valid [JCE];
    logic [31:0] m_pc    [JCE];
    logic [31:0] m_tgt   [JCE];
    bit          m_link  [JCE];

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign im_rdata = mem_word(im_addr);

    ifetch_unit #(.JC_ENTRIES(JCE), .RESET_PC(32'h0)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable_regwalls    (enable_regwalls),
        .do_hazard          (do_hazard),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .jc_update          (jc_update),
        .jc_update_pc       (jc_update_pc),
        .jc_update_target   (jc_update_target),
        .jc_update_link     (jc_update_link),
        .im_req             (im_req),
        .im_addr            (im_addr),
        .im_ready           (im_ready),
        .im_rdata           (im_rdata),
        .oIF_instruction    (oIF_instruction),
        .oIF_current_pc     (oIF_current_pc),
        .oIF_do_jcache      (oIF_do_jcache),
        .oIF_do_jcache_link (oIF_do_jcache_link),
        .fetch_busy         (fetch_busy),
        .state              (state)
    );

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < JCE; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] pc, input logic [31:0] tgt, input bit lnk);
        int idx;
        idx = int'((pc >> 2) % JCE);
        m_valid[idx] = 1'b1;
        m_pc[idx]    = pc;
        m_tgt[idx]   = tgt & ~32'h3;
        m_link[idx]  = lnk;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit hit, output logic [31:0] tgt, output bit lnk);
        int idx;
        idx = int'((pc >> 2) % JCE);
        hit = JC_ON && m_valid[idx] && (m_pc[idx] == pc);
        tgt = m_tgt[idx];
        lnk = hit && m_link[idx];
    endtask

    task automatic check_bubble(input string tag, input logic [31:0] addr);
        check({tag, "_busy"}, fetch_busy, 1'b1);
        check({tag, "_req"}, im_req, 1'b1);
        check({tag, "_addr"}, im_addr, addr);
        check({tag, "_instr"}, oIF_instruction, NOP_INSTR);
        check({tag, "_jc"}, {oIF_do_jcache, oIF_do_jcache_link}, 2'b00);
    endtask

    // Fetch at exp_pc with a number of wait cycles; optional jump-table write on the completing edge.
    task automatic fetch(input int waits, input bit upd, input logic [31:0] upd_pc,
                         input logic [31:0] upd_tgt, input bit upd_link);
        bit          hit;
        logic [31:0] tgt;
        bit          lnk;
        check_bubble("req", exp_pc);
        for (int w = 0; w < waits; w++) begin
            im_ready = 1'b0;
            tick();
            check_bubble("wait", exp_pc);
        end
        model_lookup(exp_pc, hit, tgt, lnk);
        im_ready         = 1'b1;
        jc_update        = upd;
        jc_update_pc     = upd_pc;
        jc_update_target = upd_tgt;
        jc_update_link   = upd_link;
        tick();
        im_ready  = 1'b0;
        jc_update = 1'b0;
        if (upd && JC_ON) model_write(upd_pc, upd_tgt, upd_link);
        check("valid_state", 32'(state), 32'(S_VALID));
        check("valid_busy", fetch_busy, 1'b0);
        check("valid_req", im_req, 1'b0);
        check("valid_instr", oIF_instruction, mem_word(exp_pc));
        check("valid_pc", oIF_current_pc, exp_pc);
        check("valid_jc", oIF_do_jcache, hit);
        check("valid_link", oIF_do_jcache_link, lnk);
        exp_next = hit ? tgt : exp_pc + 32'd4;
    endtask

    task automatic consume(input int hold);
        logic [31:0] instr;
        logic [31:0] cpc;
        instr = mem_word(exp_pc);
        cpc   = exp_pc;
        do_hazard = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_busy", fetch_busy, 1'b0);
            check("hold_instr", oIF_instruction, instr);
            check("hold_pc", oIF_current_pc, cpc);
        end
        do_hazard       = 1'b0;
        enable_regwalls = 1'b1;
        tick();
        exp_pc = exp_next;
    endtask

    task automatic redirect_valid(input logic [31:0] npc);
        redirect    = 1'b1;
        redirect_pc = npc;
        tick();
        redirect = 1'b0;
        exp_pc   = npc;
        check("redir_state", 32'(state), 32'(S_REQ));
    endtask

    task automatic redirect_wait(input logic [31:0] npc, input int pre, input int post);
        logic [31:0] old;
        old      = exp_pc;
        im_ready = 1'b0;
        for (int i = 0; i < pre; i++) tick();
        redirect    = 1'b1;
        redirect_pc = npc;
        tick();
        redirect = 1'b0;
        check("drop_state", 32'(state), 32'(S_DROP));
        check_bubble("drop", old);
        for (int i = 0; i < post; i++) begin
            tick();
            check_bubble("drop_wait", old);
        end
        im_ready = 1'b1;
        tick();
        im_ready = 1'b0;
        exp_pc   = npc;
        check_bubble("after_drop", npc);
    endtask

    task automatic jc_write_wait(input logic [31:0] pc, input logic [31:0] tgt, input bit lnk);
        im_ready         = 1'b0;
        jc_update        = 1'b1;
        jc_update_pc     = pc;
        jc_update_target = tgt;
        jc_update_link   = lnk;
        tick();
        jc_update = 1'b0;
        if (JC_ON) model_write(pc, tgt, lnk);
        check_bubble("jcw", exp_pc);
    endtask

    initial begin
        reset            = 1'b1;
        enable_regwalls  = 1'b1;
        do_hazard        = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = '0;
        jc_update        = 1'b0;
        jc_update_pc     = '0;
        jc_update_target = '0;
        jc_update_link   = 1'b0;
        im_ready         = 1'b0;
        model_clear();
        tick();
        tick();
        reset  = 1'b0;
        exp_pc = 32'h0;
        check("rst_state", 32'(state), 32'(S_REQ));
        check("rst_pc", oIF_current_pc, 32'h0);
        check_bubble("rst", 32'h0);

        // Zero-wait stream, then a two-cycle wait at 8, hazard hold, continue at 12.
        fetch(0, 0, 0, 0, 0); consume(0);
        fetch(0, 0, 0, 0, 0); consume(0);
        fetch(2, 0, 0, 0, 0); consume(3);
        fetch(0, 0, 0, 0, 0); consume(0);

        // Redirect mid-wait: stale word must never surface.
        redirect_wait(32'h100, 1, 0);
        fetch(0, 0, 0, 0, 0); consume(0);

        // Record jump 0x10 -> 0x80 with link, then fetch it.
        fetch(0, 1, 32'h10, 32'h80, 1'b1);
        redirect_valid(32'h10);
        fetch(0, 0, 0, 0, 0); consume(0);
        check("jump_dest", im_addr, JC_ON ? 32'h80 : 32'h14);
        fetch(1, 0, 0, 0, 0); consume(0);

        // Randomized traffic kept in a small window so the table hits often.
        for (int it = 0; it < 40; it++) begin
            int          r;
            bit          upd;
            logic [31:0] upc;
            upd = ($urandom_range(0, 2) == 0);
            upc = ($urandom_range(0, 1) == 0) ? exp_pc : 32'($urandom_range(0, 15)) << 2;
            fetch($urandom_range(0, 3), upd, upc, 32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            if (r < 2) begin
                redirect_valid(32'($urandom_range(0, 15)) << 2);
            end else begin
                consume($urandom_range(0, 2));
                if (r == 2) redirect_wait(32'($urandom_range(0, 15)) << 2, $urandom_range(0, 1), $urandom_range(0, 2));
            end
        end

        // Reset during a wait clears outputs, PC and every table entry.
        jc_write_wait(32'h10, 32'h80, 1'b1);
        im_ready = 1'b0;
        tick();
        reset    = 1'b1;
        im_ready = 1'b1;
        tick();
        reset    = 1'b0;
        im_ready = 1'b0;
        model_clear();
        exp_pc = 32'h0;
        check("rst2_state", 32'(state), 32'(S_REQ));
        check("rst2_pc", oIF_current_pc, 32'h0);
        check_bubble("rst2", 32'h0);
        fetch(0, 0, 0, 0, 0);
        redirect_valid(32'h10);
        fetch(0, 0, 0, 0, 0); consume(0);
        check("rst2_next", im_addr, 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
